popcount_acc_ctrl: RTL and testbench

//  Job sequencer for the binary dot-product datapath: accepts a job of LEN 64-bit

---
 rtl/popcount_acc_ctrl.sv | 153 +++++++++++++++
 tb/tb_popcount_acc_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_acc_ctrl.sv
// Job sequencer for the binary dot-product datapath: streams LEN 64-bit XNOR words through
// a pipelined popcount and returns one accumulated sum per job over valid/ready.
// state | meaning
// IDLE  | waiting for start; len latched on accepted start
// RUN   | accepting words until len have been taken
// DRAIN | words still in the popcount pipeline, no new input
// DONE  | out_sum valid, held until out_ready

module popcount64 #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        en_i,
    input  logic [63:0] data_i,
    output logic [6:0]  count_o
);
    logic [6:0] cnt_c;

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < 64; i++) begin
            cnt_c = cnt_c + 7'(data_i[i]);
        end
    end

    // Pipeline registers carry no reset; the caller masks them with its own valid tracker.
    if (LATENCY == 0) begin : g_comb
        assign count_o = cnt_c;
    end else begin : g_pipe
        logic [6:0] stage_q [LATENCY];

        always_ff @(posedge clk) begin
            if (en_i) begin
                stage_q[0] <= cnt_c;
                for (int i = 1; i < LATENCY; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign count_o = stage_q[LATENCY-1];
    end
endmodule

module popcount_acc_ctrl #(
    parameter int LATENCY = 2,
    parameter int LEN_W   = 16,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             accept;
    logic             pc_valid;
    logic             drain_last;
    logic [6:0]       pc_count;

    assign accept = in_valid & in_ready;

    popcount64 #(.LATENCY(LATENCY)) u_popcount (
        .clk     (clk),
        .en_i    (1'b1),
        .data_i  (in_data),
        .count_o (pc_count)
    );

    if (LATENCY == 0) begin : g_no_track
        assign pc_valid   = accept;
        assign drain_last = 1'b0;
    end else begin : g_track
        localparam logic [LATENCY-1:0] LAST_ONLY = LATENCY'(1) << (LATENCY - 1);
        logic [LATENCY-1:0] vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_q <= '0;
            else     vld_q <= (vld_q << 1) | LATENCY'(accept);
        end

        assign pc_valid   = vld_q[LATENCY-1];
        // In DRAIN nothing new enters, so the newest word is last out once it is alone.
        assign drain_last = (vld_q == LAST_ONLY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (pc_valid) acc_d = acc_q + ACC_W'(pc_count);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = out_valid ? acc_q : '0;
endmodule

// File: tb/tb_popcount_acc_ctrl.sv
// Directed bench for popcount_acc_ctrl: table of single-pattern jobs plus hand-written
// sequences for reset, zero-length, back-pressure and a LATENCY 0..3 long-job sweep.
module tb_popcount_acc_ctrl;
    localparam int LEN_W = 16;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;

    logic             sw_start = 1'b0;
    logic [LEN_W-1:0] sw_len = '0;
    logic             sw_in_valid = 1'b0;
    logic [63:0]      sw_in_data = '0;
    logic             sw_out_ready = 1'b0;
    logic             sw_busy [4];
    logic             sw_in_ready [4];
    logic             sw_out_valid [4];
    logic [ACC_W-1:0] sw_out_sum [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] wq[$];

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [63:0]      word;
        bit               gaps;
        logic [ACC_W-1:0] exp_sum;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    popcount_acc_ctrl #(.LATENCY(2), .LEN_W(LEN_W), .ACC_W(ACC_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        popcount_acc_ctrl #(.LATENCY(g), .LEN_W(LEN_W), .ACC_W(ACC_W)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .start     (sw_start),
            .len       (sw_len),
            .busy      (sw_busy[g]),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[g]),
            .in_data   (sw_in_data),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .out_sum   (sw_out_sum[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input bit gaps, output int last_acc);
        int i = 0;
        int guard = 0;
        last_acc = -1;
        while (i < wq.size() && guard < 1000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = wq[i];
            @(negedge clk);
            if (in_valid && in_ready) begin
                i++;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (i < wq.size()) chk("feed_timeout", 64'(i), 64'(wq.size()));
    endtask

    task automatic wait_out(input int budget, output int seen);
        seen = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic accept_out(input string tag);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_after_hs"}, 64'(busy), 64'd0);
        chk({tag, "_valid_after_hs"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int last;
        int seen;
        int acc_n [4];
        int last_a [4];
        int seen_s [4];
        logic [ACC_W-1:0] sum_s [4];
        bit all_seen;
        logic [63:0] ones;
        ones = '1;

        vecs[0] = '{16'd1,  64'h0000_0000_0000_0001, 1'b0, 24'd1};
        vecs[1] = '{16'd5,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 24'd320};
        vecs[2] = '{16'd8,  64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 24'd256};
        vecs[3] = '{16'd3,  64'h0000_0000_0000_0000, 1'b1, 24'd0};
        vecs[4] = '{16'd2,  64'h8000_0000_0000_0001, 1'b0, 24'd4};
        vecs[5] = '{16'd16, 64'h0000_0000_0000_00FF, 1'b1, 24'd128};

        // reset state
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // three all-ones words back to back
        start_job(16'd3);
        wq = '{ones, ones, ones};
        feed(1'b0, last);
        wait_out(20, seen);
        chk("t1_latency", 64'(seen - last), 64'd3);
        chk("t1_sum", 64'(out_sum), 64'd192);
        chk("t1_busy", 64'(busy), 64'd1);
        accept_out("t1");

        // mixed words with random gaps; input held valid after the last word
        start_job(16'd4);
        wq = '{64'h0, 64'h1, 64'h8000_0000_0000_0000, 64'hF0F0_F0F0_F0F0_F0F0};
        feed(1'b1, last);
        in_valid = 1'b1;
        in_data  = ones;
        @(negedge clk);
        chk("t2_in_ready_drain", 64'(in_ready), 64'd0);
        wait_out(20, seen);
        chk("t2_sum", 64'(out_sum), 64'd34);
        chk("t2_in_ready_done", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        accept_out("t2");

        // zero-length job
        start_job(16'd0);
        @(negedge clk);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_sum", 64'(out_sum), 64'd0);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        accept_out("t3");

        // back-pressure in DONE with stray start pulses
        start_job(16'd2);
        start = 1'b1;
        len   = 16'd7;
        wq = '{64'hFF, 64'h3};
        feed(1'b0, last);
        wait_out(20, seen);
        chk("t4_sum", 64'(out_sum), 64'd10);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_sum", 64'(out_sum), 64'd10);
        end
        start = 1'b0;
        accept_out("t4");
        @(negedge clk);
        chk("t4_no_queued_start", 64'(busy), 64'd0);

        // table-driven jobs
        for (int v = 0; v < 6; v++) begin
            start_job(vecs[v].len);
            wq.delete();
            for (int j = 0; j < int'(vecs[v].len); j++) wq.push_back(vecs[v].word);
            feed(vecs[v].gaps, last);
            wait_out(40, seen);
            chk($sformatf("vec%0d_latency", v), 64'(seen - last), 64'd3);
            chk($sformatf("vec%0d_sum", v), 64'(out_sum), 64'(vecs[v].exp_sum));
            accept_out($sformatf("vec%0d", v));
        end

        // async reset with two words in flight
        start_job(16'd4);
        wq = '{ones, ones};
        feed(1'b0, last);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_sum", 64'(out_sum), 64'd0);
        start = 1'b1;
        len   = 16'd1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wq = '{64'hFF};
        feed(1'b0, last);
        wait_out(20, seen);
        chk("t5_sum", 64'(out_sum), 64'd8);
        accept_out("t5");

        // LATENCY sweep, full-length all-ones job on four instances in parallel
        for (int g = 0; g < 4; g++) begin
            acc_n[g]  = 0;
            last_a[g] = -1;
            seen_s[g] = -1;
            sum_s[g]  = '0;
        end
        sw_out_ready = 1'b1;
        sw_in_data   = ones;
        @(posedge clk); #1;
        sw_start = 1'b1;
        sw_len   = 16'hFFFF;
        @(posedge clk); #1;
        sw_start    = 1'b0;
        sw_in_valid = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            all_seen = 1'b1;
            for (int g = 0; g < 4; g++) begin
                if (sw_in_ready[g]) begin
                    acc_n[g]++;
                    last_a[g] = cyc;
                end
                if (sw_out_valid[g] && seen_s[g] < 0) begin
                    seen_s[g] = cyc;
                    sum_s[g]  = sw_out_sum[g];
                end
                if (seen_s[g] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        sw_in_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep%0d_seen", g), 64'(seen_s[g] >= 0), 64'd1);
            chk($sformatf("sweep%0d_words", g), 64'(acc_n[g]), 64'd65535);
            chk($sformatf("sweep%0d_sum", g), 64'(sum_s[g]), 64'd4194240);
            chk($sformatf("sweep%0d_latency", g), 64'(seen_s[g] - last_a[g]), 64'(g + 1));
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep%0d_idle", g), 64'(sw_busy[g]), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
